// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the domain reset sequencer.
// Imported by the sequencer top and its testbench.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      RELEASE,
      DONE,
      HOLD
   } seq_state_e;

   localparam int unsigned DEF_DELAY_CYC    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous reset to RST_VAL.
// With d_i tied high it is an async-assert/sync-deassert reset.
module sync_2ff #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Orders reset release across the C-PHY master clock/reset domains.
// Waits for PLL lock, then releases domain resets one at a time.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_DOM        = 4,
   parameter int unsigned DELAY_CYC    = DEF_DELAY_CYC,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned CNT_W        = $clog2(LOCK_TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             RstN,
   input  logic             pll_lock,
   input  logic             sw_rst_req,
   output logic [N_DOM-1:0] rst_n_out,
   output logic             seq_done,
   output logic             busy,
   output logic             lock_err
);

   localparam int unsigned DOM_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DELAY_CYC - 1);
   localparam logic [DOM_W-1:0] DOM_ONE   = DOM_W'(1);
   localparam logic [DOM_W-1:0] DOM_LAST  = DOM_W'(N_DOM - 1);

   logic rst_s;
   logic lock_s;
   logic abort;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DOM_W-1:0] dom_q, dom_d;
   logic [N_DOM-1:0] rst_q, rst_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_rst_sync (
      .clk     (clk),
      .rst_n_i (RstN),
      .d_i     (1'b1),
      .q_o     (rst_s)
   );

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_lock_sync (
      .clk     (clk),
      .rst_n_i (RstN),
      .d_i     (pll_lock),
      .q_o     (lock_s)
   );

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         dom_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dom_q   <= dom_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dom_d   = dom_q;
      rst_d   = rst_q;
      err_d   = err_q;
      abort   = sw_rst_req |
                (~lock_s & ((state_q == RELEASE) |
                            (state_q == DONE)));

      if (state_q == HOLD) begin
         if (sw_rst_req) begin
            cnt_d = '0;
            err_d = 1'b0;
         end else if (cnt_q == DLY_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            dom_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (abort) begin
         // Abort beats any release scheduled for this same cycle.
         state_d = HOLD;
         cnt_d   = '0;
         dom_d   = '0;
         rst_d   = '0;
         if (sw_rst_req) begin
            err_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_C) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            RELEASE: begin
               if (cnt_q == DLY_LAST) begin
                  rst_d[dom_q] = 1'b1;
                  cnt_d        = '0;
                  if (dom_q == DOM_LAST) begin
                     state_d = DONE;
                  end else begin
                     dom_d = dom_q + DOM_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end

      done_d = (state_d == DONE);
      busy_d = (state_d != DONE);
   end

   assign rst_n_out = rst_q;
   assign seq_done  = done_q;
   assign busy      = busy_q;
   assign lock_err  = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against a timeline model.
// Expected outputs are derived from elapsed edges per phase.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int N  = 4;
   localparam int D  = 16;
   localparam int LT = 1024;

   logic         clk        = 1'b0;
   logic         RstN       = 1'b1;
   logic         pll_lock   = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic [N-1:0] rst_n_out;
   logic         seq_done;
   logic         busy;
   logic         lock_err;

   int n_tests = 0;
   int n_fail  = 0;

   reset_sequencer #(
      .N_DOM        (N),
      .DELAY_CYC    (D),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clk        (clk),
      .RstN       (RstN),
      .pll_lock   (pll_lock),
      .sw_rst_req (sw_rst_req),
      .rst_n_out  (rst_n_out),
      .seq_done   (seq_done),
      .busy       (busy),
      .lock_err   (lock_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Timeline model: phase plus the edge at which it began.
   typedef enum {P_WAIT, P_SEQ, P_DONE, P_HOLD} phase_e;
   phase_e ph   = P_WAIT;
   int     e    = 0;
   int     t0   = 2;
   int     rel  = 0;
   bit     err  = 1'b0;
   bit     p1   = 1'b0;
   bit     p2   = 1'b0;
   bit     ls;
   bit     sw;
   bit     ab;

   always @(posedge clk or negedge RstN) begin
      if (!RstN) begin
         ph = P_WAIT; e = 0; t0 = 2; rel = 0;
         err = 1'b0; p1 = 1'b0; p2 = 1'b0;
      end else begin
         ls = p2;
         sw = sw_rst_req;
         p2 = p1;
         p1 = pll_lock;
         e++;
         if (e >= 3) begin
            ab = sw || (!ls && (ph == P_SEQ || ph == P_DONE));
            if (ph == P_HOLD) begin
               if (sw) begin
                  t0 = e; err = 1'b0;
               end else if (e - t0 == D) begin
                  ph = P_WAIT; t0 = e;
               end
            end else if (ab) begin
               ph = P_HOLD; t0 = e; rel = 0;
               if (sw) err = 1'b0;
            end else if (ph == P_WAIT) begin
               if (ls) begin
                  ph = P_SEQ; t0 = e; rel = 0;
               end else if (e - 1 - t0 >= LT) begin
                  err = 1'b1;
               end
            end else if (ph == P_SEQ) begin
               rel = (e - t0) / D;
               if (rel >= N) begin
                  rel = N; ph = P_DONE;
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_vec();
      logic [N-1:0] r;
      if (e < 3) return 32'd0;
      r = '0;
      if (ph == P_SEQ)  r = N'((1 << rel) - 1);
      if (ph == P_DONE) r = '1;
      return {25'd0, r, ph == P_DONE, ph != P_DONE, err};
   endfunction

   function automatic logic [31:0] obs_vec();
      return {25'd0, rst_n_out, seq_done, busy, lock_err};
   endfunction

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("cycle", obs_vec(), exp_vec());
         sw_rst_req = 1'b0;
      end
   endtask

   task automatic wait_pat(input logic [N-1:0] pat);
      int k;
      k = 0;
      while (rst_n_out !== pat && k < 400) begin
         cyc(1);
         k++;
      end
      check("wait_pat", {28'd0, rst_n_out}, {28'd0, pat});
   endtask

   initial begin
      int sel;
      #2 RstN = 1'b0;
      #21;
      check("reset", obs_vec(), 32'd0);
      @(negedge clk);
      RstN = 1'b1;

      // Power-up with lock already present.
      cyc(70);
      check("pwr_done", {28'd0, rst_n_out}, 32'hF);
      check("pwr_flags", {30'd0, seq_done, busy}, 32'h2);

      // Lock loss in DONE for 5 cycles.
      pll_lock = 1'b0;
      cyc(3);
      check("drop", {27'd0, rst_n_out, seq_done}, 32'd0);
      cyc(2);
      pll_lock = 1'b1;
      cyc(80);
      check("drop_reseq", {28'd0, rst_n_out}, 32'hF);

      // Long lock loss leads to timeout.
      pll_lock = 1'b0;
      cyc(1100);
      check("tout_err", {31'd0, lock_err}, 32'd1);
      check("tout_out", {28'd0, rst_n_out}, 32'd0);
      pll_lock = 1'b1;
      wait_pat(4'b0011);
      check("tout_keep", {31'd0, lock_err}, 32'd1);

      // Software request right after 0011.
      sw_rst_req = 1'b1;
      cyc(1);
      check("sw_abort", {27'd0, rst_n_out, busy}, 32'h1);
      check("sw_errclr", {31'd0, lock_err}, 32'd0);
      cyc(100);
      check("sw_reseq", {28'd0, rst_n_out}, 32'hF);

      // Software request on the domain-2 release edge.
      sw_rst_req = 1'b1;
      cyc(1);
      wait_pat(4'b0011);
      cyc(15);
      sw_rst_req = 1'b1;
      cyc(1);
      check("coinc", {28'd0, rst_n_out}, 32'd0);
      cyc(100);

      // Short RstN pulse mid-RELEASE, no clock edge.
      sw_rst_req = 1'b1;
      cyc(30);
      #2 RstN = 1'b0;
      #1;
      check("async_rst", obs_vec(), 32'd0);
      RstN = 1'b1;
      cyc(80);
      check("rst_reseq", {28'd0, rst_n_out}, 32'hF);

      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 2) begin
            sw_rst_req = 1'b1;
            cyc($urandom_range(1, 40));
         end else if (sel < 5) begin
            pll_lock = 1'b0;
            cyc($urandom_range(1, 30));
            pll_lock = 1'b1;
            cyc($urandom_range(1, 80));
         end else begin
            cyc($urandom_range(1, 100));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Orders reset release across the C-PHY master's clock/reset domains after power-on, PLL lock, or software reset request. The global RstN is synchronized internally. The block waits for PLL lock, then releases per-domain active-low resets one at a time with a fixed spacing. It re-asserts all domain resets on lock loss or software request, and flags a lock timeout. Sits at the top of the master between the pad reset and all domain reset synchronizers.

Parameters:
N_DOM, 4, number of sequenced reset domains; domain 0 is released first.
DELAY_CYC, 16, clk cycles between lock detection and each successive domain release; also the hold time in HOLD; must be >= 1.
LOCK_TIMEOUT, 1024, clk cycles in WAIT_LOCK before lock_err is set.
CNT_W, $clog2(LOCK_TIMEOUT+1), width of the shared cycle counter; must also cover DELAY_CYC.

Ports:
clk  input  1  sequencer clock, free-running reference clock.
RstN  input  1  asynchronous active-low global reset.
pll_lock  input  1  PLL lock indicator, asynchronous to clk.
sw_rst_req  input  1  single-cycle software reset request, synchronous to clk.
rst_n_out  output  N_DOM  per-domain active-low resets, registered.
seq_done  output  1  high while all domains are released.
busy  output  1  high while the sequence is in progress (WAIT_LOCK, RELEASE, HOLD).
lock_err  output  1  sticky lock-timeout flag.

Behaviour:
- Reset is asynchronous, active-low on RstN; clock is clk.
- RstN is passed through a 2-flop synchronizer that asserts asynchronously and de-asserts synchronously (rst_s). All FSM flops are reset by rst_s.
- pll_lock is passed through a 2-flop synchronizer (lock_s), giving 2 cycles of latency.
- Reset values: rst_n_out=0, seq_done=0, busy=0, lock_err=0, state=WAIT_LOCK, counter=0, dom_idx=0.
- States:
  - WAIT_LOCK: busy=1. The counter counts up each cycle, saturating at LOCK_TIMEOUT. When the counter reaches LOCK_TIMEOUT with lock_s=0, lock_err is set and the FSM keeps waiting. When lock_s=1, clear the counter and go to RELEASE.
  - RELEASE: busy=1. The counter counts to DELAY_CYC-1. On that cycle, set rst_n_out[dom_idx]=1 (visible next cycle) and clear the counter.
    - If dom_idx==N_DOM-1, go to DONE; otherwise increment dom_idx.
    - rst_n_out[k] therefore rises exactly (k+1)*DELAY_CYC cycles after the first RELEASE cycle.
  - DONE: seq_done=1, busy=0, all rst_n_out=1.
  - HOLD: rst_n_out=0, busy=1. Count DELAY_CYC cycles, then clear the counter and dom_idx and go to WAIT_LOCK.
- Abort: from WAIT_LOCK, RELEASE or DONE, either sw_rst_req=1 or (lock_s=0 while in RELEASE/DONE) causes the following on the next edge:
  - all rst_n_out=0 and seq_done=0;
  - state=HOLD, counter=0, dom_idx=0.
- sw_rst_req in HOLD restarts the HOLD count from 0.
- Simultaneous events:
  - sw_rst_req and lock loss in the same cycle produce a single abort.
  - sw_rst_req on the same cycle as a scheduled domain release: the abort wins and no release occurs.
- lock_err clears only on RstN or on an accepted sw_rst_req; lock loss does not clear it.
- RstN asserted mid-sequence: all outputs go to their reset values asynchronously, independent of clk.
- Outputs are driven directly from flops, with no combinational path from any input.
- Shared counter: width CNT_W, saturating, no wrap-around.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum {WAIT_LOCK, RELEASE, DONE, HOLD};
  - default constants for DELAY_CYC and LOCK_TIMEOUT.
- Sub-module sync_2ff (WIDTH param): 2-flop synchronizer, used for pll_lock.
- The RstN synchronizer is the async-assert/sync-deassert variant built from the same sync_2ff, with its D input tied high.

Test Plan (default parameters):
- Power-up with pll_lock already high, RstN deasserted -> rst_n_out goes 0001, 0011, 0111, 1111 at 16-cycle intervals starting 16 cycles after the first RELEASE cycle; seq_done=1 with 1111; busy falls on the same edge.
- pll_lock held low 1100 cycles -> lock_err=1 at WAIT_LOCK cycle 1024, rst_n_out=0000; raise pll_lock -> normal sequence completes and lock_err stays 1.
- In DONE, drop pll_lock for 5 cycles -> rst_n_out=0000 and seq_done=0 3 cycles after the drop (2 sync + 1); HOLD 16 cycles; then resequence once lock returns.
- sw_rst_req pulse in RELEASE right after rst_n_out=0011 -> next cycle rst_n_out=0000, busy=1; full resequence from domain 0; lock_err cleared.
- sw_rst_req coincident with the domain-2 release cycle -> no 0111 state ever observed; 0000 on the next edge.
- Assert RstN for 1 ns mid-RELEASE (no clk edge) -> rst_n_out=0000, seq_done=0, busy=0, lock_err=0 immediately; the sequence restarts after RstN release and 2 sync cycles.
